// File: rtl/hps_stream_ctrl_pkg.sv
// Shared definitions for the HPS-to-CNN stream controller.
// Covers the register map, the STATUS/CTRL bit positions, the FSM states and a STATUS packing helper.
package hps_stream_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_EMPTY   = 3;
  localparam int ST_FULL    = 4;
  localparam int ST_LVL_LSB = 8;

  localparam int CTRL_START  = 31;
  localparam int CTRL_ABORT  = 30;
  localparam int CTRL_IRQ_EN = 29;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  function automatic logic [31:0] pack_status(
    input logic       busy,
    input logic       done,
    input logic       ovf,
    input logic       empty,
    input logic       full,
    input logic [7:0] level
  );
    logic [31:0] s;
    s                          = '0;
    s[ST_BUSY]                 = busy;
    s[ST_DONE]                 = done;
    s[ST_OVF]                  = ovf;
    s[ST_EMPTY]                = empty;
    s[ST_FULL]                 = full;
    s[ST_LVL_LSB+7:ST_LVL_LSB] = level;
    return s;
  endfunction

endpackage

// File: rtl/hps_stream_ctrl_if.sv
// Bundles the Avalon-MM register port and the valid/ready output stream of the controller.
// The master modport is the HPS/datapath side; the controller uses the slave modport.
interface hps_stream_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_data, out_valid, out_last
  );

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_data, out_valid, out_last
  );
endinterface

// File: rtl/hps_stream_fifo.sv
// Synchronous word FIFO with wrap-around pointers carrying one extra bit.
// Has a first-word fall-through read port, a flush input and a level output.
module hps_stream_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AW:0]       level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || pop_i) && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/hps_stream_ctrl.sv
// HPS stream controller: Avalon-MM register decode, frame FSM, remaining-word counter and sticky flags.
// Define HPS_STREAM_CTRL_IRQ_EN to add CTRL[29] irq enable and the registered irq output.
module hps_stream_ctrl
  import hps_stream_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  hps_stream_ctrl_if.slave   bus
`ifdef HPS_STREAM_CTRL_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              wr_en, data_wr, status_wr, ctrl_wr;
  logic              start_req, abort_req;
  logic [LEN_W-1:0]  new_len;
  logic              streaming, abort, handshake, ovf_set;
  logic              fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              unused_wdata;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign data_wr   = wr_en && (bus.address == ADDR_DATA);
  assign status_wr = wr_en && (bus.address == ADDR_STATUS);
  assign ctrl_wr   = wr_en && (bus.address == ADDR_CTRL);
  assign start_req = ctrl_wr && bus.writedata[CTRL_START];
  assign abort_req = ctrl_wr && bus.writedata[CTRL_ABORT];
  assign new_len   = bus.writedata[LEN_W-1:0];

  // Not every CTRL bit is implemented; fold the whole word so none is left dangling.
  assign unused_wdata = ^bus.writedata;

  assign streaming = (state_q == STREAM);
  assign abort     = streaming && abort_req;
  assign handshake = bus.out_valid && bus.out_ready && !abort;
  assign ovf_set   = data_wr && fifo_full && !handshake;

  assign bus.out_valid = streaming && !fifo_empty;
  assign bus.out_last  = bus.out_valid && (remaining_q == LEN_W'(1));
  assign bus.out_data  = bus.out_valid ? fifo_rdata : '0;

  hps_stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .flush_i (abort),
    .push_i  (data_wr),
    .wdata_i (bus.writedata[DATA_W-1:0]),
    .pop_i   (handshake),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    done_d      = done_q;
    ovf_d       = ovf_q;

    // Clears come first so a same-cycle set below wins.
    if (status_wr && bus.writedata[ST_DONE]) done_d = 1'b0;
    if (status_wr && bus.writedata[ST_OVF])  ovf_d  = 1'b0;
    if (ovf_set)                             ovf_d  = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start_req && (new_len != '0)) begin
          state_d     = STREAM;
          remaining_d = new_len;
          len_d       = new_len;
          done_d      = 1'b0;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (handshake) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef HPS_STREAM_CTRL_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q;

  assign irq_en_d = ctrl_wr ? bus.writedata[CTRL_IRQ_EN] : irq_en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_q && irq_en_q;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      ADDR_DATA:   bus.readdata = '0;
      ADDR_STATUS: bus.readdata = pack_status(streaming, done_q, ovf_q, fifo_empty,
                                              fifo_full, 8'(fifo_level));
      ADDR_CTRL: begin
        bus.readdata[LEN_W-1:0] = len_q;
`ifdef HPS_STREAM_CTRL_IRQ_EN
        bus.readdata[CTRL_IRQ_EN] = irq_en_q;
`endif
      end
      ADDR_COUNT:  bus.readdata[LEN_W-1:0] = remaining_q;
      default:     bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hps_stream_ctrl.sv
// Directed bench for hps_stream_ctrl (DATA_W=32, DEPTH=8, LEN_W=16).
// Inputs change and outputs are sampled around the falling clock edge.
module tb_hps_stream_ctrl;
  import hps_stream_ctrl_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;
`ifdef HPS_STREAM_CTRL_IRQ_EN
  logic irq;
`endif

  hps_stream_ctrl_if #(.DATA_W(32)) bus ();

  hps_stream_ctrl #(
    .DATA_W (32),
    .DEPTH  (8),
    .LEN_W  (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef HPS_STREAM_CTRL_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one write cycle starting now; returns at the falling edge after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.readdata, exp);
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    reset_n        = 1'b1;
    bus.address    = ADDR_DATA;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.out_ready  = 1'b0;

    // Reset state
    #3 reset_n = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_last",  32'(bus.out_last),  32'h0);
    check("rst_data",  bus.out_data,       32'h0);
    chk_reg("rst_status", ADDR_STATUS, 32'h0000_0008);
    chk_reg("rst_count",  ADDR_COUNT,  32'h0);
    chk_reg("rst_ctrl",   ADDR_CTRL,   32'h0);
`ifdef HPS_STREAM_CTRL_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Preload three words, then stream a frame of three
    wr(ADDR_DATA, 32'h11);
    wr(ADDR_DATA, 32'h22);
    wr(ADDR_DATA, 32'h33);
    chk_reg("pre_status", ADDR_STATUS, 32'h0000_0300);
    check("pre_idle_valid", 32'(bus.out_valid), 32'h0);
    wr(ADDR_CTRL, 32'h8000_0003);
    check("pre_valid0", 32'(bus.out_valid), 32'h1);
    check("pre_data0",  bus.out_data,       32'h11);
    check("pre_last0",  32'(bus.out_last),  32'h0);
    chk_reg("pre_count3",  ADDR_COUNT,  32'h3);
    chk_reg("pre_busy",    ADDR_STATUS, 32'h0000_0301);
    chk_reg("pre_ctrl",    ADDR_CTRL,   32'h3);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("pre_data1", bus.out_data,      32'h22);
    check("pre_last1", 32'(bus.out_last), 32'h0);
    @(negedge clk);
    check("pre_data2", bus.out_data,      32'h33);
    check("pre_last2", 32'(bus.out_last), 32'h1);
    chk_reg("pre_count1", ADDR_COUNT, 32'h1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("pre_end_valid", 32'(bus.out_valid), 32'h0);
    chk_reg("pre_done",   ADDR_STATUS, 32'h0000_000A);
    chk_reg("pre_count0", ADDR_COUNT,  32'h0);
    wr(ADDR_STATUS, 32'h2);
    chk_reg("done_w1c", ADDR_STATUS, 32'h0000_0008);

    // Backpressure: head word held for five stalled cycles
    wr(ADDR_DATA, 32'hA1);
    wr(ADDR_DATA, 32'hA2);
    wr(ADDR_CTRL, 32'h8000_0002);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(bus.out_valid), 32'h1);
      check("bp_hold_data",  bus.out_data,       32'hA1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("bp_last0", 32'(bus.out_last), 32'h0);
    @(negedge clk);
    check("bp_data1", bus.out_data,      32'hA2);
    check("bp_last1", 32'(bus.out_last), 32'h1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_end_valid", 32'(bus.out_valid), 32'h0);
    chk_reg("bp_done", ADDR_STATUS, 32'h0000_000A);
    wr(ADDR_STATUS, 32'h2);

    // Start ignored for N=0; pass-through into an empty FIFO while streaming
    wr(ADDR_CTRL, 32'h8000_0000);
    chk_reg("n0_idle", ADDR_STATUS, 32'h0000_0008);
    wr(ADDR_CTRL, 32'h8000_0001);
    check("pt_empty_valid", 32'(bus.out_valid), 32'h0);
    chk_reg("pt_busy", ADDR_STATUS, 32'h0000_0009);
    wr(ADDR_DATA, 32'h55);
    check("pt_valid", 32'(bus.out_valid), 32'h1);
    check("pt_data",  bus.out_data,       32'h55);
    check("pt_last",  32'(bus.out_last),  32'h1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("pt_end_data", bus.out_data, 32'h0);
    chk_reg("pt_done", ADDR_STATUS, 32'h0000_000A);
    wr(ADDR_STATUS, 32'h2);

    // Overflow: ninth word into a full FIFO is dropped
    for (int i = 0; i < 9; i++) wr(ADDR_DATA, 32'h100 + 32'(i));
    chk_reg("ovf_status", ADDR_STATUS, 32'h0000_0814);
    wr(ADDR_STATUS, 32'h4);
    chk_reg("ovf_w1c", ADDR_STATUS, 32'h0000_0810);
    // Full FIFO with a same-cycle pop accepts the word
    wr(ADDR_CTRL, 32'h8000_0008);
    chk_reg("full_busy", ADDR_STATUS, 32'h0000_0811);
    bus.out_ready = 1'b1;
    wr(ADDR_DATA, 32'h1FF);
    chk_reg("full_pushpop", ADDR_STATUS, 32'h0000_0811);
    chk_reg("full_count7",  ADDR_COUNT,  32'h7);
    for (int i = 1; i < 8; i++) begin
      check("ovf_data", bus.out_data,      32'h100 + 32'(i));
      check("ovf_last", 32'(bus.out_last), (i == 7) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check("ovf_end_valid", 32'(bus.out_valid), 32'h0);
    chk_reg("ovf_leftover", ADDR_STATUS, 32'h0000_0102);
    wr(ADDR_STATUS, 32'h2);
    wr(ADDR_CTRL, 32'h8000_0001);
    check("ovf_next_head", bus.out_data, 32'h1FF);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk_reg("ovf_drained", ADDR_STATUS, 32'h0000_000A);
    wr(ADDR_STATUS, 32'h2);

    // Abort with a concurrent handshake
    for (int i = 0; i < 6; i++) wr(ADDR_DATA, 32'h200 + 32'(i));
    wr(ADDR_CTRL, 32'h8000_000A);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ab_data", bus.out_data, 32'h200 + 32'(i));
      @(negedge clk);
    end
    chk_reg("ab_count6", ADDR_COUNT, 32'h6);
    wr(ADDR_CTRL, 32'h4000_0000);
    bus.out_ready = 1'b0;
    check("ab_valid", 32'(bus.out_valid), 32'h0);
    chk_reg("ab_status", ADDR_STATUS, 32'h0000_0008);
    chk_reg("ab_count",  ADDR_COUNT,  32'h0);
    chk_reg("ab_ctrl",   ADDR_CTRL,   32'hA);

    // Reset mid-frame
    wr(ADDR_DATA, 32'h301);
    wr(ADDR_DATA, 32'h302);
    wr(ADDR_CTRL, 32'h8000_0005);
    check("mr_valid_before", 32'(bus.out_valid), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_valid", 32'(bus.out_valid), 32'h0);
    check("mr_last",  32'(bus.out_last),  32'h0);
    check("mr_data",  bus.out_data,       32'h0);
    chk_reg("mr_status", ADDR_STATUS, 32'h0000_0008);
    chk_reg("mr_count",  ADDR_COUNT,  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr(ADDR_CTRL, 32'h8000_0000);
    chk_reg("mr_n0_idle", ADDR_STATUS, 32'h0000_0008);
    wr(ADDR_DATA, 32'h77);
    check("mr_idle_valid", 32'(bus.out_valid), 32'h0);
    chk_reg("mr_level1", ADDR_STATUS, 32'h0000_0100);

`ifdef HPS_STREAM_CTRL_IRQ_EN
    // Interrupt follows done with one cycle of lag
    wr(ADDR_CTRL, 32'h2000_0000);
    chk_reg("irq_ctrl", ADDR_CTRL, 32'h2000_0000);
    wr(ADDR_CTRL, 32'hA000_0001);
    bus.out_ready = 1'b1;
    check("irq_data", bus.out_data, 32'h77);
    check("irq_pre",  32'(irq),     32'h0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("irq_lag", 32'(irq), 32'h0);
    chk_reg("irq_done", ADDR_STATUS, 32'h0000_000A);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    wr(ADDR_STATUS, 32'h2);
    check("irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'h0);
`else
    // Without the irq option CTRL[29] is not stored
    wr(ADDR_CTRL, 32'h2000_0000);
    chk_reg("noirq_ctrl", ADDR_CTRL, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
